// File: rtl/common.sv
// Shared compute-side types: datapath word width.
// Imported wherever compute words are handled.
package common;
  localparam int COMP_DATA_BITS = 64;
endpackage

// File: rtl/line_unpacker_pkg.sv
// Types local to the line unpacker.
// State encoding for the emit FSM.
package line_unpacker_pkg;
  typedef enum logic {
    ST_IDLE,
    ST_EMIT
  } unpack_state_e;
endpackage

// File: rtl/lynxTypes.sv
// Shared platform types: AXI stream line width.
// Imported wherever a full memory line is handled.
package lynxTypes;
  localparam int AXI_DATA_BITS = 512;
endpackage

// File: rtl/AXI4S.sv
// Shared AXI4-Stream bundle.
// m drives the beat, s returns tready.
interface AXI4S #(
  parameter int AXI4S_DATA_BITS = lynxTypes::AXI_DATA_BITS
) ();
  logic [AXI4S_DATA_BITS-1:0]   tdata;
  logic [AXI4S_DATA_BITS/8-1:0] tkeep;
  logic                         tlast;
  logic                         tvalid;
  logic                         tready;

  modport m (
    output tdata, tkeep, tlast, tvalid,
    input  tready
  );

  modport s (
    input  tdata, tkeep, tlast, tvalid,
    output tready
  );
endinterface

// File: rtl/first_lane_enc.sv
// Lowest-set-lane priority encoder.
// last is high when no lane above idx is set.
module first_lane_enc #(
  parameter  int N_LANES = 8,
  localparam int IDX_W   = $clog2(N_LANES)
) (
  input  logic [N_LANES-1:0] mask,
  output logic [IDX_W-1:0]   idx,
  output logic               last
);

  logic [N_LANES-1:0] above;

  always_comb begin
    idx = '0;
    for (int i = N_LANES - 1; i >= 0; i--) begin
      if (mask[i]) idx = IDX_W'(i);
    end
  end

  assign above = mask >> idx;
  assign last  = ~|above[N_LANES-1:1];

endmodule

// File: rtl/line_unpacker.sv
// Splits wide stream lines into word beats,
// skipping lanes whose keep bits are all clear.
module line_unpacker #(
  parameter int IN_BITS  = lynxTypes::AXI_DATA_BITS,
  parameter int OUT_BITS = common::COMP_DATA_BITS
) (
  input logic clk,
  input logic rst_n,
  AXI4S.s     i_data,
  AXI4S.m     o_data
);
  import line_unpacker_pkg::*;

  localparam int N_LANES = IN_BITS / OUT_BITS;
  localparam int IDX_W   = $clog2(N_LANES);
  localparam int KB_IN   = IN_BITS / 8;
  localparam int KB_OUT  = OUT_BITS / 8;

  unpack_state_e      state;
  logic [IN_BITS-1:0] line_data;
  logic [KB_IN-1:0]   line_keep;
  logic               line_last;
  logic [N_LANES-1:0] mask;
  logic [N_LANES-1:0] lanes_nz;
  logic [N_LANES-1:0] next_mask;
  logic [IDX_W-1:0]   idx;
  logic               final_w;
  logic               in_hs;
  logic               out_hs;

  always_comb begin
    lanes_nz = '0;
    for (int i = 0; i < N_LANES; i++) begin
      lanes_nz[i] = |i_data.tkeep[KB_OUT*i +: KB_OUT];
    end
  end

  // an all-empty closing line still owes one tlast beat, carried on lane 0
  assign next_mask = lanes_nz
                   | N_LANES'(~|lanes_nz & i_data.tlast);

  first_lane_enc #(
    .N_LANES(N_LANES)
  ) u_enc (
    .mask(mask),
    .idx (idx),
    .last(final_w)
  );

  assign i_data.tready = rst_n
                      && (state == ST_IDLE
                      || (o_data.tready && final_w));

  assign in_hs  = i_data.tvalid && i_data.tready;
  assign out_hs = o_data.tvalid && o_data.tready;

  assign o_data.tvalid = (state == ST_EMIT);
  assign o_data.tdata  = line_data[OUT_BITS*int'(idx) +: OUT_BITS];
  assign o_data.tkeep  = line_keep[KB_OUT*int'(idx) +: KB_OUT];
  assign o_data.tlast  = line_last && final_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mask      <= '0;
      line_data <= '0;
      line_keep <= '0;
      line_last <= 1'b0;
    end else if (in_hs) begin
      line_data <= i_data.tdata;
      line_keep <= i_data.tkeep;
      line_last <= i_data.tlast;
      mask      <= next_mask;
      state     <= (|next_mask) ? ST_EMIT : ST_IDLE;
    end else if (out_hs) begin
      mask <= mask & ~(N_LANES'(1) << idx);
      if (final_w) state <= ST_IDLE;
    end
  end

endmodule

// File: tb/tb_line_unpacker.sv
// Scoreboard bench for line_unpacker.
// Expected words are queued on input accept, popped on output.
module tb_line_unpacker;

  localparam int IB = 512;
  localparam int OB = 64;
  localparam int NL = IB / OB;
  localparam int KO = OB / 8;

  typedef struct {
    logic [OB-1:0] data;
    logic [KO-1:0] keep;
    logic          last;
    bit            dchk;
  } word_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  AXI4S #(.AXI4S_DATA_BITS(IB)) in_if ();
  AXI4S #(.AXI4S_DATA_BITS(OB)) out_if ();

  line_unpacker #(
    .IN_BITS (IB),
    .OUT_BITS(OB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .i_data(in_if),
    .o_data(out_if)
  );

  always #5 clk = ~clk;

  word_t         sb[$];
  int            hs_cyc[$];
  int            acc_cyc[$];
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_bad = 0;
  bit            rdy_rand = 0;
  bit            stall = 0;
  logic [OB-1:0] st_data;
  logic [KO-1:0] st_keep;
  logic          st_last;
  word_t         mw;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (rdy_rand) out_if.tready = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model(input logic [IB-1:0] d,
                                input logic [IB/8-1:0] k,
                                input logic l);
    int    hi = -1;
    word_t w;
    for (int i = 0; i < NL; i++)
      if (|k[KO*i +: KO]) hi = i;
    if (hi < 0) begin
      if (l) begin
        w.data = '0;
        w.keep = '0;
        w.last = 1'b1;
        w.dchk = 0;
        sb.push_back(w);
      end
      return;
    end
    for (int i = 0; i < NL; i++) begin
      if (|k[KO*i +: KO]) begin
        w.data = d[OB*i +: OB];
        w.keep = k[KO*i +: KO];
        w.last = l && (i == hi);
        w.dchk = 1;
        sb.push_back(w);
      end
    end
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      stall = 0;
    end else begin
      if (stall) begin
        chk("stall_valid", 64'(out_if.tvalid), 64'(1));
        chk("stall_data", out_if.tdata, st_data);
        chk("stall_keep", 64'(out_if.tkeep), 64'(st_keep));
        chk("stall_last", 64'(out_if.tlast), 64'(st_last));
      end
      stall   = out_if.tvalid && !out_if.tready;
      st_data = out_if.tdata;
      st_keep = out_if.tkeep;
      st_last = out_if.tlast;
      if (in_if.tvalid && in_if.tready) begin
        model(in_if.tdata, in_if.tkeep, in_if.tlast);
        acc_cyc.push_back(cyc);
      end
      if (out_if.tvalid && out_if.tready) begin
        hs_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          chk("extra_word", 64'(1), 64'(0));
        end else begin
          mw = sb.pop_front();
          if (mw.dchk) chk("word_data", out_if.tdata, mw.data);
          chk("word_keep", 64'(out_if.tkeep), 64'(mw.keep));
          chk("word_last", 64'(out_if.tlast), 64'(mw.last));
        end
      end
    end
  end

  function automatic logic [IB-1:0] rnd_line();
    logic [IB-1:0] d;
    for (int i = 0; i < IB / 32; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  task automatic send_line(input logic [IB-1:0] d,
                           input logic [IB/8-1:0] k,
                           input logic l);
    bit ok = 0;
    in_if.tdata  = d;
    in_if.tkeep  = k;
    in_if.tlast  = l;
    in_if.tvalid = 1'b1;
    for (int t = 0; t < 500 && !ok; t++) begin
      @(negedge clk);
      ok = in_if.tready;
      @(posedge clk);
      #1;
    end
    if (!ok) chk("in_timeout", 64'(0), 64'(1));
    in_if.tvalid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    bit done = 0;
    for (int t = 0; t < 4000 && !done; t++) begin
      if (sb.size() == 0 && !out_if.tvalid) done = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk(tag, 64'(sb.size()), 64'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    hs_cyc.delete();
    acc_cyc.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IB/8-1:0] k;
    logic [IB-1:0]   d;
    bit              ok;
    int              r;

    in_if.tvalid  = 1'b0;
    in_if.tdata   = '0;
    in_if.tkeep   = '0;
    in_if.tlast   = 1'b0;
    out_if.tready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ovalid", 64'(out_if.tvalid), 64'(0));
    chk("rst_iready", 64'(in_if.tready), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_iready", 64'(in_if.tready), 64'(1));
    @(posedge clk);
    #1;

    // full line, all lanes kept
    clear_log();
    send_line(rnd_line(), '1, 1'b1);
    wait_drain("full_drain");
    chk("full_words", 64'(hs_cyc.size()), 64'(8));
    if (hs_cyc.size() == 8 && acc_cyc.size() == 1) begin
      chk("full_span", 64'(hs_cyc[7] - hs_cyc[0]), 64'(7));
      chk("full_lat", 64'(hs_cyc[0] - acc_cyc[0]), 64'(1));
    end

    // sparse line: lane 0 full, lane 2 partial, lane 1 skipped
    clear_log();
    k = '0;
    k[7:0]   = 8'hFF;
    k[23:16] = 8'h0F;
    send_line(rnd_line(), k, 1'b1);
    wait_drain("sparse_drain");
    chk("sparse_words", 64'(hs_cyc.size()), 64'(2));
    if (hs_cyc.size() == 2)
      chk("sparse_gap", 64'(hs_cyc[1] - hs_cyc[0]), 64'(1));

    // back-to-back: 4-lane line then 8-lane line
    clear_log();
    k = '0;
    k[31:0] = '1;
    send_line(rnd_line(), k, 1'b1);
    send_line(rnd_line(), '1, 1'b1);
    wait_drain("b2b_drain");
    chk("b2b_words", 64'(hs_cyc.size()), 64'(12));
    if (hs_cyc.size() == 12 && acc_cyc.size() == 2) begin
      chk("b2b_span", 64'(hs_cyc[11] - hs_cyc[0]), 64'(11));
      chk("b2b_accept", 64'(acc_cyc[1]), 64'(hs_cyc[3]));
    end

    // keep-zero lines
    clear_log();
    send_line(rnd_line(), '0, 1'b1);
    wait_drain("kz_last_drain");
    chk("kz_last_words", 64'(hs_cyc.size()), 64'(1));
    clear_log();
    send_line(rnd_line(), '0, 1'b0);
    @(negedge clk);
    chk("kz_iready", 64'(in_if.tready), 64'(1));
    chk("kz_ovalid", 64'(out_if.tvalid), 64'(0));
    repeat (4) @(posedge clk);
    #1;
    chk("kz_nolast_words", 64'(hs_cyc.size()), 64'(0));

    // reset mid-line after three words
    clear_log();
    send_line(rnd_line(), '1, 1'b1);
    ok = 0;
    for (int t = 0; t < 50 && !ok; t++) begin
      if (hs_cyc.size() >= 3) ok = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk("mid_three", 64'(ok), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_ovalid", 64'(out_if.tvalid), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_log();
    @(negedge clk);
    chk("mid_iready", 64'(in_if.tready), 64'(1));
    repeat (12) @(posedge clk);
    #1;
    chk("mid_stale", 64'(hs_cyc.size()), 64'(0));

    // random lines under random backpressure
    rdy_rand = 1;
    for (int n = 0; n < 100; n++) begin
      k = '0;
      for (int i = 0; i < NL; i++) begin
        r = $urandom_range(0, 3);
        if (r == 1 || r == 3) k[KO*i +: KO] = '1;
        else if (r == 2) k[KO*i +: KO] = 8'($urandom_range(1, 254));
      end
      if ($urandom_range(0, 9) == 0) k = '0;
      d = rnd_line();
      send_line(d, k, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    wait_drain("rand_drain");
    rdy_rand = 0;
    out_if.tready = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
